rgbw_frame_dispatcher: RTL and testbench

Frame assembler between the SPI byte receiver and the colour generator. It consumes the byte stream and byte-ready strobe produced by the SPI slave, groups bytes into fixed 8-byte frames and checks a per-frame checksum. Valid frames are committed atomically to the mode, intensity, colour-index and RGBW setpoint registers that feed the colour/PWM path. Malformed, aborted or stalled frames are discarded and counted, and the outputs never show a partial update.

---
 rtl/rgbw_frame_dispatcher.sv | 230 +++++++++++++++++++++++
 tb/tb_rgbw_frame_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_frame_dispatcher.sv
// rgbw_frame_dispatcher
// Purpose: assembles the SPI byte stream into fixed 8-byte frames
// (mode, lint, colorIdx, R, G, B, W, checksum). It commits a frame to the
// colour-path setpoint registers only when the frame's XOR checksum matches,
// and it commits all seven setpoints on the same edge. Aborted, stalled or
// corrupt frames are dropped and counted.
// Ports:
//   clk            system clock (same clock as the SPI slave)
//   reset          synchronous, active-high reset
//   cs_n           raw SPI chip select, asynchronous; synchronised in here
//   rx_data        received byte, stable while rx_rdy is high
//   rx_rdy         byte-ready level from the SPI slave; rising edge = one byte
//   mode_sync .. white_sync  committed setpoints
//   upd            one-cycle pulse in the first cycle new setpoints are visible
//   frm_err        one-cycle pulse per discarded frame
//   err_cnt        saturating count of discarded frames
module rgbw_frame_dispatcher #(
    parameter int unsigned           TO_W    = 16,
    parameter logic [TO_W-1:0]       TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic [7:0] mode_sync,
    output logic [7:0] lint_sync,
    output logic [7:0] colorIdx_sync,
    output logic [7:0] red_sync,
    output logic [7:0] green_sync,
    output logic [7:0] blue_sync,
    output logic [7:0] white_sync,
    output logic       upd,
    output logic       frm_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // The timer reads 0 in the first cycle after an accept, so deciding the
    // abort at count TIMEOUT-3 puts the frm_err pulse TIMEOUT-1 cycles after
    // the last accepted byte. A byte landing in the decision cycle still wins.
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT > TO_W'(3)) ? (TIMEOUT - TO_W'(3)) : '0;

    // One step of the running checksum fold.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      stage_q [7];
    logic [7:0]      stage_d [7];
    logic [7:0]      xor_q, xor_d;
    logic            match_q, match_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      mode_q, mode_d, lint_q, lint_d, cidx_q, cidx_d;
    logic [7:0]      red_q, red_d, green_q, green_d, blue_q, blue_d, white_q, white_d;
    logic            upd_q, upd_d, frm_err_q, frm_err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            rdy_q;
    logic            cs_meta_q, cs_s_q, cs_prev_q;

    logic            accept_s, cs_rise_s, cs_fall_s, timeout_s;

    assign accept_s  = rx_rdy & ~rdy_q;
    assign cs_rise_s = cs_s_q & ~cs_prev_q;
    assign cs_fall_s = ~cs_s_q & cs_prev_q;
    assign timeout_s = (to_q >= TO_LAST);

    // Input capture: rx_rdy edge register and the cs_n synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q     <= 1'b0;
            cs_meta_q <= 1'b1;
            cs_s_q    <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            rdy_q     <= rx_rdy;
            cs_meta_q <= cs_n;
            cs_s_q    <= cs_meta_q;
            cs_prev_q <= cs_s_q;
        end
    end

    // Frame FSM: next state, staging, checksum, timer and commit decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        xor_d     = xor_q;
        match_d   = match_q;
        to_d      = to_q;
        mode_d    = mode_q;
        lint_d    = lint_q;
        cidx_d    = cidx_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        white_d   = white_q;
        upd_d     = 1'b0;
        frm_err_d = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                to_d = '0;
                if (accept_s) begin
                    stage_d[0] = rx_data;
                    xor_d      = xor_fold(8'hFF, rx_data);
                    cnt_d      = 3'd1;
                    state_d    = S_RECV;
                end else begin
                    // A falling cs edge here is just the normal frame start.
                    xor_d = 8'hFF;
                    cnt_d = 3'd0;
                end
            end
            S_RECV: begin
                if (accept_s) begin
                    to_d = '0;
                    if (cnt_q == 3'd7) begin
                        match_d = (rx_data == xor_q);
                        state_d = S_CHECK;
                    end else begin
                        stage_d[cnt_q] = rx_data;
                        xor_d          = xor_fold(xor_q, rx_data);
                        cnt_d          = cnt_q + 3'd1;
                    end
                end else if (cs_rise_s || cs_fall_s || timeout_s) begin
                    // Deselect, a restarted frame or a stall all end the same way.
                    state_d   = S_IDLE;
                    cnt_d     = 3'd0;
                    xor_d     = 8'hFF;
                    to_d      = '0;
                    frm_err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_CHECK: begin
                // Bytes arriving here are dropped silently.
                if (match_q) begin
                    mode_d  = stage_q[0];
                    lint_d  = stage_q[1];
                    cidx_d  = stage_q[2];
                    red_d   = stage_q[3];
                    green_d = stage_q[4];
                    blue_d  = stage_q[5];
                    white_d = stage_q[6];
                    upd_d   = 1'b1;
                end else begin
                    frm_err_d = 1'b1;
                end
                state_d = S_IDLE;
                cnt_d   = 3'd0;
                xor_d   = 8'hFF;
                to_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
                xor_d   = 8'hFF;
                to_d    = '0;
            end
        endcase

        if (frm_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            for (int i = 0; i < 7; i++) stage_q[i] <= 8'h00;
            xor_q     <= 8'hFF;
            match_q   <= 1'b0;
            to_q      <= '0;
            mode_q    <= 8'h00;
            lint_q    <= 8'h00;
            cidx_q    <= 8'h00;
            red_q     <= 8'h00;
            green_q   <= 8'h00;
            blue_q    <= 8'h00;
            white_q   <= 8'h00;
            upd_q     <= 1'b0;
            frm_err_q <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            xor_q     <= xor_d;
            match_q   <= match_d;
            to_q      <= to_d;
            mode_q    <= mode_d;
            lint_q    <= lint_d;
            cidx_q    <= cidx_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            white_q   <= white_d;
            upd_q     <= upd_d;
            frm_err_q <= frm_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mode_sync     = mode_q;
    assign lint_sync     = lint_q;
    assign colorIdx_sync = cidx_q;
    assign red_sync      = red_q;
    assign green_sync    = green_q;
    assign blue_sync     = blue_q;
    assign white_sync    = white_q;
    assign upd           = upd_q;
    assign frm_err       = frm_err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_rgbw_frame_dispatcher.sv
// Bench for rgbw_frame_dispatcher: table of directed frames, hand-written
// timing sequences, and random frames checked against a frame-level model.
module tb_rgbw_frame_dispatcher;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic [7:0] mode_sync, lint_sync, colorIdx_sync;
    logic [7:0] red_sync, green_sync, blue_sync, white_sync;
    logic       upd, frm_err;
    logic [7:0] err_cnt;

    rgbw_frame_dispatcher #(.TO_W(16), .TIMEOUT(16'd16)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .mode_sync(mode_sync), .lint_sync(lint_sync), .colorIdx_sync(colorIdx_sync),
        .red_sync(red_sync), .green_sync(green_sync), .blue_sync(blue_sync),
        .white_sync(white_sync), .upd(upd), .frm_err(frm_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [55:0] outs_w;
    assign outs_w = {mode_sync, lint_sync, colorIdx_sync, red_sync, green_sync, blue_sync, white_sync};

    int          cyc = 0;
    int          n_upd = 0, n_err = 0, n_glitch = 0;
    int          last_upd_cyc = 0, last_err_cyc = 0, last_acc = 0;
    logic [55:0] prev_outs = 56'h0;
    logic [55:0] upd_snap [$];
    int          n_vec = 0, n_bad = 0;

    // Model state: committed setpoints and discarded-frame count.
    logic [55:0] m_out;
    int          m_ecnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor and "outputs only move with upd" watcher.
    always @(negedge clk) begin
        if (upd) begin
            n_upd        <= n_upd + 1;
            last_upd_cyc <= cyc;
            upd_snap.push_back(outs_w);
        end
        if (frm_err) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
        if (!reset && !upd && (outs_w != prev_outs)) n_glitch <= n_glitch + 1;
        prev_outs <= outs_w;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left just after a falling edge; accepts are hold+gap-1 apart.
    task automatic send_byte(input logic [7:0] b, input int gap, input int hold);
        rx_data  = b;
        rx_rdy   = 1'b1;
        last_acc = cyc;
        repeat (hold) @(negedge clk);
        rx_rdy = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic run_frame(input logic [63:0] bytes, input int nsend, input int gap,
                             output int d_upd, output int d_err);
        int u0, e0;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        u0 = n_upd;
        e0 = n_err;
        for (int i = 0; i < nsend; i++) send_byte(bytes[63-8*i -: 8], gap, 1);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        d_upd = n_upd - u0;
        d_err = n_err - e0;
    endtask

    // Frame-level model: commit iff all 8 bytes arrived and b7 = FF ^ b0..b6.
    task automatic model_frame(input logic [63:0] bytes, input int nsend,
                               output int e_upd, output int e_err);
        logic [7:0] x;
        e_upd = 0;
        e_err = 0;
        x = 8'hFF;
        for (int i = 0; i < 7; i++) x = x ^ bytes[63-8*i -: 8];
        if (nsend == 8 && bytes[7:0] == x) begin
            m_out = bytes[63:8];
            e_upd = 1;
        end else begin
            e_err = 1;
            if (m_ecnt < 255) m_ecnt++;
        end
    endtask

    function automatic logic [63:0] good_frame(input logic [55:0] body);
        logic [7:0] x;
        x = 8'hFF;
        for (int i = 0; i < 7; i++) x = x ^ body[55-8*i -: 8];
        return {body, x};
    endfunction

    typedef struct {
        logic [63:0] bytes;
        int          nsend;
        logic [55:0] exp_out;
        int          exp_upd;
        int          exp_err;
        logic [7:0]  exp_ecnt;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [8];
        int          du, de, eu, ee, qb, e0;
        logic [63:0] f1, f2, fr;

        tbl[0] = '{64'h0180102040080402, 8, 56'h01801020400804, 1, 0, 8'h00};
        tbl[1] = '{64'h0180102040080403, 8, 56'h01801020400804, 0, 1, 8'h01};
        tbl[2] = '{64'h00000000000000FF, 8, 56'h00000000000000, 1, 0, 8'h01};
        tbl[3] = '{64'hFFFFFFFFFFFFFF00, 8, 56'hFFFFFFFFFFFFFF, 1, 0, 8'h01};
        tbl[4] = '{64'hAABBCCDD00000000, 4, 56'hFFFFFFFFFFFFFF, 0, 1, 8'h02};
        tbl[5] = '{64'h0180102040080402, 8, 56'h01801020400804, 1, 0, 8'h02};
        tbl[6] = '{64'h123456789ABCDE0F, 8, 56'h123456789ABCDE, 1, 0, 8'h02};
        tbl[7] = '{64'h5555555555555555, 7, 56'h123456789ABCDE, 0, 1, 8'h03};

        reset = 1'b1; cs_n = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
        m_out = 56'h0; m_ecnt = 0;
        repeat (3) @(negedge clk);
        check("rst_outs", 64'(outs_w), 64'h0);
        check("rst_upd", 64'(upd), 64'h0);
        check("rst_frm_err", 64'(frm_err), 64'h0);
        check("rst_err_cnt", 64'(err_cnt), 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].bytes, tbl[i].nsend, 3, du, de);
            model_frame(tbl[i].bytes, tbl[i].nsend, eu, ee);
            check("tbl_out", 64'(outs_w), 64'(tbl[i].exp_out));
            check("tbl_upd", 64'(du), 64'(tbl[i].exp_upd));
            check("tbl_err", 64'(de), 64'(tbl[i].exp_err));
            check("tbl_ecnt", 64'(err_cnt), 64'(tbl[i].exp_ecnt));
            if (tbl[i].exp_upd == 1) check("tbl_latency", 64'(last_upd_cyc - last_acc), 64'd2);
        end

        // Timeout: 3 bytes then silence with cs_n still low.
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        e0 = n_err;
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 3, 1);
        repeat (20) @(negedge clk);
        check("to_pulse", 64'(n_err - e0), 64'd1);
        check("to_delay", 64'(last_err_cyc - last_acc), 64'(TO - 1));
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("to_idle_no_extra", 64'(n_err - e0), 64'd1);
        m_ecnt++;
        check("to_ecnt", 64'(err_cnt), 64'(m_ecnt));
        check("to_outs_held", 64'(outs_w), 64'(m_out));

        // Gaps of 14 cycles between bytes still commit.
        fr = good_frame(56'hA1B2C3D4E5F607);
        run_frame(fr, 8, 14, du, de);
        model_frame(fr, 8, eu, ee);
        check("gap14_upd", 64'(du), 64'd1);
        check("gap14_err", 64'(de), 64'd0);
        check("gap14_out", 64'(outs_w), 64'(m_out));

        // Two frames back-to-back under one chip select.
        f1 = 64'h0180102040080402;
        f2 = 64'h123456789ABCDE0F;
        qb = upd_snap.size();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        e0 = n_err;
        for (int i = 0; i < 8; i++) send_byte(f1[63-8*i -: 8], 2, 1);
        for (int i = 0; i < 8; i++) send_byte(f2[63-8*i -: 8], 2, 1);
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        model_frame(f1, 8, eu, ee);
        model_frame(f2, 8, eu, ee);
        check("b2b_upd_count", 64'(upd_snap.size() - qb), 64'd2);
        check("b2b_err", 64'(n_err - e0), 64'd0);
        if (upd_snap.size() >= qb + 2) begin
            check("b2b_first", 64'(upd_snap[qb]), 64'(f1[63:8]));
            check("b2b_second", 64'(upd_snap[qb+1]), 64'(f2[63:8]));
        end else begin
            check("b2b_snapshots_present", 64'(upd_snap.size() - qb), 64'd2);
        end

        // rx_rdy held high for several cycles is one byte.
        fr = good_frame(56'h0F1E2D3C4B5A69);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        e0 = n_err;
        qb = n_upd;
        for (int i = 0; i < 8; i++) send_byte(fr[63-8*i -: 8], 3, (i == 3) ? 6 : 1);
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        model_frame(fr, 8, eu, ee);
        check("hold_upd", 64'(n_upd - qb), 64'd1);
        check("hold_err", 64'(n_err - e0), 64'd0);
        check("hold_out", 64'(outs_w), 64'(m_out));

        // Reset in the middle of a frame.
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        e0 = n_err;
        for (int i = 0; i < 5; i++) send_byte(8'h70 + 8'(i), 3, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        m_out = 56'h0;
        m_ecnt = 0;
        check("rstmid_outs", 64'(outs_w), 64'h0);
        check("rstmid_ecnt", 64'(err_cnt), 64'h0);
        check("rstmid_no_err", 64'(n_err - e0), 64'd0);
        fr = good_frame(56'h11223344556677);
        run_frame(fr, 8, 3, du, de);
        model_frame(fr, 8, eu, ee);
        check("rstmid_recover", 64'(outs_w), 64'(m_out));

        // Random frames against the model.
        for (int n = 0; n < 40; n++) begin
            int ns, gp;
            fr = good_frame({$urandom, 24'($urandom)});
            if ($urandom_range(0, 2) == 0) fr[7:0] = fr[7:0] ^ 8'($urandom_range(1, 255));
            ns = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            gp = $urandom_range(2, 8);
            run_frame(fr, ns, gp, du, de);
            model_frame(fr, ns, eu, ee);
            check("rnd_out", 64'(outs_w), 64'(m_out));
            check("rnd_upd", 64'(du), 64'(eu));
            check("rnd_err", 64'(de), 64'(ee));
            check("rnd_ecnt", 64'(err_cnt), 64'(m_ecnt));
            if (eu == 1) check("rnd_latency", 64'(last_upd_cyc - last_acc), 64'd2);
        end

        // 300 corrupt frames saturate the error counter.
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        e0 = n_err;
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < 7; i++) send_byte(8'(i), 2, 1);
            send_byte(8'h00, 2, 1);
        end
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("sat_pulses", 64'(n_err - e0), 64'd300);
        check("sat_ecnt", 64'(err_cnt), 64'hFF);
        check("sat_outs_held", 64'(outs_w), 64'(m_out));

        check("outs_move_only_with_upd", 64'(n_glitch), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
